ghostbus_host_seq: RTL and testbench

- Host-side initiator for the ghostbus.
- Accepts read/write commands on a valid/ready command port and drives the single-cycle ghostbus strobes (gb_addr, gb_wdata, gb_we, gb_re) into the decoded module tree.
- Samples gb_rdata after a fixed read latency and returns read data on a valid/ready response port.
- Sits between a host transport (UART/Ethernet/JTAG bridge) and the top-level ghostbus port bundle.

---
 rtl/ghostbus_host_seq.sv | 158 +++++++++++++++
 tb/tb_ghostbus_host_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghostbus_host_seq.sv
// Host-side ghostbus initiator: valid/ready commands in, one-cycle strobes out.
// Define GHOSTBUS_HOST_BURST_EN to honour cmd_len for multi-beat reads.
module ghostbus_host_seq #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int LW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [LW-1:0] cmd_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_last,
    output logic          busy,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RSP
    } state_t;

    localparam logic [3:0] LAT = 4'(RD_LAT);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          last_q, last_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          accept;
    logic          beats_left;

`ifdef GHOSTBUS_HOST_BURST_EN
    logic [LW-1:0] rem_q, rem_d;

    assign beats_left = (rem_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end
`else
    logic unused_len;

    assign unused_len = ^cmd_len;
    assign beats_left = 1'b0;
`endif

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
`ifdef GHOSTBUS_HOST_BURST_EN
        rem_d   = rem_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = cmd_addr;
`ifdef GHOSTBUS_HOST_BURST_EN
                    rem_d  = cmd_write ? '0 : cmd_len;
`endif
                    // gb_wdata only moves on writes so it holds between strobes
                    if (cmd_write) begin
                        wdata_d = cmd_wdata;
                        state_d = WR;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD_ISSUE: begin
                cnt_d   = LAT;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    rdata_d = gb_rdata;
                    last_d  = !beats_left;
                    state_d = RSP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    if (beats_left) begin
                        addr_d  = addr_q + AW'(1);
`ifdef GHOSTBUS_HOST_BURST_EN
                        rem_d   = rem_q - LW'(1);
`endif
                        state_d = RD_ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign gb_we     = (state_q == WR);
    assign gb_re     = (state_q == RD_ISSUE);
    assign gb_addr   = addr_q;
    assign gb_wdata  = wdata_q;
    assign rsp_valid = (state_q == RSP);
    assign rsp_rdata = rdata_q;
    assign rsp_last  = last_q;

endmodule

// File: tb/tb_ghostbus_host_seq.sv
// Scoreboard bench for ghostbus_host_seq with a fixed-latency read model.
// Expectations follow GHOSTBUS_HOST_BURST_EN when it is defined.
module tb_ghostbus_host_seq;

    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int LW     = 8;
    localparam int RD_LAT = 2;
`ifdef GHOSTBUS_HOST_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [LW-1:0] cmd_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_last;
    logic          busy;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata;
    logic          gb_we;
    logic          gb_re;
    logic [DW-1:0] gb_rdata;

    ghostbus_host_seq #(
        .AW(AW), .DW(DW), .LW(LW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
        .busy(busy),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata),
        .gb_we(gb_we), .gb_re(gb_re),
        .gb_rdata(gb_rdata)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } bus_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } rsp_t;

    bus_t busq[$];
    rsp_t rspq[$];

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return {8'h00, a} + 32'd2;
    endfunction

    // read model: data is only meaningful exactly RD_LAT cycles after gb_re
    logic          pv[RD_LAT];
    logic [AW-1:0] pa[RD_LAT];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
            end
        end else begin
            pv[0] <= gb_re;
            pa[0] <= gb_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    assign gb_rdata = pv[RD_LAT-1] ? mem_f(pa[RD_LAT-1])
                                   : (32'hBAD0_0000 | DW'(cyc[15:0]));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_write(input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
        busq.push_back('{1'b1, a, d});
    endtask

    task automatic push_read(input logic [AW-1:0] a,
                             input logic [LW-1:0] l);
        int n;
        logic [AW-1:0] x;
        n = BURST ? int'(l) + 1 : 1;
        for (int i = 0; i < n; i++) begin
            x = a + AW'(i);
            busq.push_back('{1'b0, x, '0});
            rspq.push_back('{mem_f(x), (i == n - 1)});
        end
    endtask

    // monitor
    logic          prev_valid = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    int            re_cyc = 0;
    bus_t          bm;
    rsp_t          rm;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (gb_we && gb_re) chk("we_re_overlap", 1, 0);
            if (gb_we || gb_re) begin
                if (busq.size() == 0) begin
                    chk("bus_unexpected", {gb_we, gb_addr}, 0);
                end else begin
                    bm = busq.pop_front();
                    chk("bus_kind", gb_we, bm.we);
                    chk("bus_addr", gb_addr, bm.a);
                    if (bm.we) chk("bus_wdata", gb_wdata, bm.d);
                end
                if (gb_re) re_cyc = cyc;
            end
            if (rsp_valid && !prev_valid)
                chk("rd_latency", cyc - re_cyc, RD_LAT + 1);
            if (prev_stall) begin
                chk("stall_valid", rsp_valid, 1);
                chk("stall_data", rsp_rdata, prev_d);
                chk("stall_last", rsp_last, prev_l);
            end
            if (rsp_valid && rsp_ready) begin
                if (rspq.size() == 0) begin
                    chk("rsp_unexpected", rsp_rdata, 0);
                end else begin
                    rm = rspq.pop_front();
                    chk("rsp_data", rsp_rdata, rm.d);
                    chk("rsp_last", rsp_last, rm.last);
                end
            end
            prev_valid = rsp_valid;
            prev_stall = rsp_valid && !rsp_ready;
            prev_d     = rsp_rdata;
            prev_l     = rsp_last;
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [LW-1:0] l);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_len   = l;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (busq.size() == 0 && rspq.size() == 0 && !busy) break;
        end
        chk("drain_left", busq.size() + rspq.size(), 0);
    endtask

    task automatic wait_re(input int target);
        int seen;
        seen = 0;
        for (int k = 0; k < 100 && seen < target; k++) begin
            @(negedge clk);
            if (gb_re) seen++;
        end
        chk("re_seen", seen, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_len   = '0;
        rsp_ready = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_outs", {rsp_valid, rsp_last, busy, gb_we, gb_re}, 0);
        chk("rst_bus", {gb_addr, gb_wdata, rsp_rdata}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);

        // single write
        push_write(24'h000010, 32'hDEADBEEF);
        send(1'b1, 24'h000010, 32'hDEADBEEF, 8'd0);
        @(negedge clk);
        chk("wr_busy", busy, 1);
        chk("wr_we", gb_we, 1);
        @(negedge clk);
        chk("wr_busy_end", busy, 0);
        chk("wr_no_rsp", rsp_valid, 0);
        chk("wr_addr_hold", gb_addr, 24'h000010);
        chk("wr_data_hold", gb_wdata, 32'hDEADBEEF);

        // single read
        rsp_ready = 1'b1;
        push_read(24'h000040, 8'd0);
        send(1'b0, 24'h000040, 32'h0, 8'd0);
        drain(100);

        // wrapping burst with a stalled first beat
        rsp_ready = 1'b0;
        push_read(24'hFFFFFE, 8'd3);
        send(1'b0, 24'hFFFFFE, 32'h0, 8'd3);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                break;
            end
        end
        chk("stall_rsp_seen", ok, 1);
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain(200);

        // write then read with cmd_valid held high
        push_write(24'h000020, 32'hCAFEF00D);
        push_read(24'h000030, 8'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 24'h000020;
        cmd_wdata = 32'hCAFEF00D;
        cmd_len   = 8'd0;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        chk("b2b_first_accept", ok, 1);
        @(posedge clk); #1;
        cmd_write = 1'b0;
        cmd_addr  = 24'h000030;
        @(negedge clk);
        chk("b2b_ready_wr", cmd_ready, 0);
        chk("b2b_we", gb_we, 1);
        @(negedge clk);
        chk("b2b_ready_idle", cmd_ready, 1);
        chk("b2b_re_idle", gb_re, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_re", gb_re, 1);
        drain(100);

        // len ignored without burst support, six beats with it
        push_read(24'h000080, 8'd5);
        send(1'b0, 24'h000080, 32'h0, 8'd5);
        drain(200);

        if (BURST) begin
            push_read(24'h000200, 8'hFF);
            send(1'b0, 24'h000200, 32'h0, 8'hFF);
            drain(2000);
        end

        // reset inside RD_WAIT
        push_read(24'h000100, 8'd3);
        send(1'b0, 24'h000100, 32'h0, 8'd3);
        wait_re(BURST ? 2 : 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", cmd_ready, 0);
        chk("mid_rst_outs", {rsp_valid, rsp_last, busy, gb_we, gb_re}, 0);
        chk("mid_rst_bus", {gb_addr, gb_wdata, rsp_rdata}, 0);
        busq.delete();
        rspq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_busy", busy, 0);
        repeat (6) @(negedge clk);
        chk("post_rst_stale", rsp_valid, 0);

        push_read(24'h000055, 8'd0);
        send(1'b0, 24'h000055, 32'h0, 8'd0);
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
